// File: rtl/segment_pkg.sv
// Shared types for the segment-register load path: target index, fault codes,
// controller state encoding and the descriptor bit positions that VALIDATE inspects.
package segment_pkg;

    typedef enum logic [2:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_index_t;

    typedef enum logic [2:0] {
        FLT_NONE           = 3'd0,
        FLT_BAD_INDEX      = 3'd1,
        FLT_NULL_CS_SS     = 3'd2,
        FLT_LIMIT          = 3'd3,
        FLT_TYPE           = 3'd4,
        FLT_NOT_PRESENT    = 3'd5,
        FLT_SS_NOT_PRESENT = 3'd6
    } load_fault_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ_LO,
        ST_WAIT_LO,
        ST_REQ_HI,
        ST_WAIT_HI,
        ST_VALIDATE,
        ST_DONE
    } load_state_t;

    localparam int DESC_S_BIT = 44;
    localparam int DESC_P_BIT = 47;

    // Null selector: index and TI both zero, RPL is don't-care.
    function automatic logic is_null_selector(input logic [15:0] sel);
        return (sel[15:2] == 14'd0);
    endfunction

endpackage

// File: rtl/segment_descriptor_check.sv
// Combinational descriptor validation: system descriptors are rejected first,
// then not-present descriptors, with SS getting its own not-present code.
module segment_descriptor_check
    import segment_pkg::*;
(
    input  logic [2:0]  i_index,
    input  logic [63:0] i_descriptor,
    output logic        o_fault,
    output load_fault_t o_fault_code
);

    always_comb begin
        o_fault      = 1'b0;
        o_fault_code = FLT_NONE;
        if (!i_descriptor[DESC_S_BIT]) begin
            o_fault      = 1'b1;
            o_fault_code = FLT_TYPE;
        end else if (!i_descriptor[DESC_P_BIT]) begin
            o_fault = 1'b1;
            if (i_index == SEG_SS) begin
                o_fault_code = FLT_SS_NOT_PRESENT;
            end else begin
                o_fault_code = FLT_NOT_PRESENT;
            end
        end
    end

endmodule

// File: rtl/segment_load_controller.sv
// Segment-register load sequencer: selector checks, two 32-bit descriptor reads,
// validation, then a one-cycle write/done pulse. One memory request outstanding at a time.
module segment_load_controller
    import segment_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LIMIT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [2:0]             load_index,
    input  logic [15:0]            load_selector,
    input  logic [ADDR_WIDTH-1:0]  gdtr_base,
    input  logic [LIMIT_WIDTH-1:0] gdtr_limit,
    input  logic [ADDR_WIDTH-1:0]  ldtr_base,
    input  logic [LIMIT_WIDTH-1:0] ldtr_limit,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_address,
    input  logic                   mem_rsp_valid,
    input  logic [31:0]            mem_rsp_data,
    output logic                   write_enable,
    output logic [2:0]             write_index,
    output logic [15:0]            write_selector,
    output logic [63:0]            write_descriptor,
    output logic                   done_valid,
    output logic                   fault,
    output logic [2:0]             fault_code
);

    localparam int CW = (LIMIT_WIDTH > 16) ? LIMIT_WIDTH : 16;

    load_state_t           r_state;
    logic [2:0]            r_index;
    logic [15:0]           r_selector;
    logic [63:0]           r_desc;
    logic                  r_load_ready;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_req_address;
    logic                  r_write_enable;
    logic [2:0]            r_write_index;
    logic [15:0]           r_write_selector;
    logic [63:0]           r_write_descriptor;
    logic                  r_done_valid;
    logic                  r_fault;
    logic [2:0]            r_fault_code;

    logic                   w_null_sel;
    logic [ADDR_WIDTH-1:0]  w_base;
    logic [LIMIT_WIDTH-1:0] w_limit;
    logic [CW-1:0]          w_entry_end;
    logic [CW-1:0]          w_limit_ext;
    logic [ADDR_WIDTH-1:0]  w_offset;
    logic                   w_chk_fault;
    load_fault_t            w_chk_code;

    assign w_null_sel  = is_null_selector(r_selector);
    assign w_base      = r_selector[2] ? ldtr_base  : gdtr_base;
    assign w_limit     = r_selector[2] ? ldtr_limit : gdtr_limit;
    // Last byte of the 8-byte entry must lie within the table limit.
    assign w_entry_end = CW'({r_selector[15:3], 3'b111});
    assign w_limit_ext = CW'(w_limit);
    assign w_offset    = ADDR_WIDTH'({r_selector[15:3], 3'b000});

    segment_descriptor_check u_check (
        .i_index      (r_index),
        .i_descriptor (r_desc),
        .o_fault      (w_chk_fault),
        .o_fault_code (w_chk_code)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_index            <= '0;
            r_selector         <= '0;
            r_desc             <= '0;
            r_load_ready       <= 1'b1;
            r_mem_req_valid    <= 1'b0;
            r_mem_req_address  <= '0;
            r_write_enable     <= 1'b0;
            r_write_index      <= '0;
            r_write_selector   <= '0;
            r_write_descriptor <= '0;
            r_done_valid       <= 1'b0;
            r_fault            <= 1'b0;
            r_fault_code       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_index      <= load_index;
                        r_selector   <= load_selector;
                        r_desc       <= '0;
                        r_load_ready <= 1'b0;
                        r_state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_index > SEG_GS) begin
                        r_done_valid <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= FLT_BAD_INDEX;
                        r_state      <= ST_DONE;
                    end else if (w_null_sel && (r_index == SEG_CS || r_index == SEG_SS)) begin
                        r_done_valid <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= FLT_NULL_CS_SS;
                        r_state      <= ST_DONE;
                    end else if (w_null_sel) begin
                        r_done_valid       <= 1'b1;
                        r_write_enable     <= 1'b1;
                        r_write_index      <= r_index;
                        r_write_selector   <= r_selector;
                        r_write_descriptor <= '0;
                        r_state            <= ST_DONE;
                    end else if (w_entry_end > w_limit_ext) begin
                        r_done_valid <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= FLT_LIMIT;
                        r_state      <= ST_DONE;
                    end else begin
                        r_mem_req_valid   <= 1'b1;
                        r_mem_req_address <= w_base + w_offset;
                        r_state           <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (mem_rsp_valid) begin
                        r_desc[31:0]      <= mem_rsp_data;
                        r_mem_req_valid   <= 1'b1;
                        r_mem_req_address <= r_mem_req_address + ADDR_WIDTH'(4);
                        r_state           <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (mem_rsp_valid) begin
                        r_desc[63:32] <= mem_rsp_data;
                        r_state       <= ST_VALIDATE;
                    end
                end
                ST_VALIDATE: begin
                    r_done_valid <= 1'b1;
                    r_fault      <= w_chk_fault;
                    r_fault_code <= w_chk_code;
                    if (!w_chk_fault) begin
                        r_write_enable     <= 1'b1;
                        r_write_index      <= r_index;
                        r_write_selector   <= r_selector;
                        r_write_descriptor <= r_desc;
                    end
                    r_state <= ST_DONE;
                end
                default: begin
                    r_done_valid       <= 1'b0;
                    r_fault            <= 1'b0;
                    r_fault_code       <= '0;
                    r_write_enable     <= 1'b0;
                    r_write_index      <= '0;
                    r_write_selector   <= '0;
                    r_write_descriptor <= '0;
                    r_load_ready       <= 1'b1;
                    r_state            <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_ready       = r_load_ready;
    assign mem_req_valid    = r_mem_req_valid;
    assign mem_req_address  = r_mem_req_address;
    assign write_enable     = r_write_enable;
    assign write_index      = r_write_index;
    assign write_selector   = r_write_selector;
    assign write_descriptor = r_write_descriptor;
    assign done_valid       = r_done_valid;
    assign fault            = r_fault;
    assign fault_code       = r_fault_code;

endmodule

// File: tb/tb_segment_load_controller.sv
// Bench for segment_load_controller: directed scenarios plus randomized loads
// checked against a rule-level reference model and a simple memory model.
module tb_segment_load_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [2:0]  load_index = '0;
    logic [15:0] load_selector = '0;
    logic [31:0] gdtr_base = '0;
    logic [15:0] gdtr_limit = '0;
    logic [31:0] ldtr_base = '0;
    logic [15:0] ldtr_limit = '0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_address;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        write_enable;
    logic [2:0]  write_index;
    logic [15:0] write_selector;
    logic [63:0] write_descriptor;
    logic        done_valid;
    logic        fault;
    logic [2:0]  fault_code;

    segment_load_controller #(.ADDR_WIDTH(32), .LIMIT_WIDTH(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_index       (load_index),
        .load_selector    (load_selector),
        .gdtr_base        (gdtr_base),
        .gdtr_limit       (gdtr_limit),
        .ldtr_base        (ldtr_base),
        .ldtr_limit       (ldtr_limit),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_address  (mem_req_address),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .write_enable     (write_enable),
        .write_index      (write_index),
        .write_selector   (write_selector),
        .write_descriptor (write_descriptor),
        .done_valid       (done_valid),
        .fault            (fault),
        .fault_code       (fault_code)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model and observation log
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] addr_q [$];
    bit          hs = 1'b0;
    logic [31:0] hs_addr = '0;
    bit          stray = 1'b0;
    bit          rnd_ready = 1'b0;
    int          stall_left = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          stab_err = 0;
    int          obs_done_cnt = 0;
    int          obs_done_cyc = 0;
    int          obs_we_cnt = 0;
    logic        obs_fault = 1'b0;
    logic [2:0]  obs_code = '0;
    logic [2:0]  obs_wi = '0;
    logic [15:0] obs_ws = '0;
    logic [63:0] obs_wd = '0;
    bit          obs_timeout = 1'b0;
    int          acc_cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 32'hDEADBEEF;
    endfunction

    initial begin
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_rsp_valid = hs || stray;
            mem_rsp_data  = hs ? mem_rd(hs_addr) : $urandom;
            hs    = 1'b0;
            stray = 1'b0;
            if (stall_left > 0) begin
                mem_req_ready = 1'b0;
                if (mem_req_valid) stall_left--;
            end else begin
                mem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (pend && (!mem_req_valid || mem_req_address !== pend_addr)) stab_err++;
        if (mem_req_valid && mem_req_ready) begin
            addr_q.push_back(mem_req_address);
            hs      = 1'b1;
            hs_addr = mem_req_address;
            pend    = 1'b0;
        end else if (mem_req_valid) begin
            pend      = 1'b1;
            pend_addr = mem_req_address;
        end else begin
            pend = 1'b0;
        end
        if (write_enable) begin
            obs_we_cnt++;
            obs_wi = write_index;
            obs_ws = write_selector;
            obs_wd = write_descriptor;
        end
        if (done_valid) begin
            obs_done_cnt++;
            obs_done_cyc = cyc;
            obs_fault    = fault;
            obs_code     = fault_code;
        end
    end

    // Reference model derived directly from the load rules.
    function automatic void model(input logic [2:0] idx, input logic [15:0] sel,
                                  input logic [31:0] lo, input logic [31:0] hi,
                                  output logic [2:0] code, output int nmem,
                                  output logic [31:0] a0, output logic [31:0] a1,
                                  output logic we, output logic [63:0] desc);
        int          lim;
        int          entry_end;
        logic [31:0] base;
        code = 3'd0; nmem = 0; a0 = '0; a1 = '0; we = 1'b0; desc = '0;
        if (idx > 3'd5) begin
            code = 3'd1;
        end else if ((sel >> 2) == 16'd0) begin
            if (idx == 3'd1 || idx == 3'd2) code = 3'd2;
            else we = 1'b1;
        end else begin
            lim       = sel[2] ? int'(ldtr_limit) : int'(gdtr_limit);
            base      = sel[2] ? ldtr_base : gdtr_base;
            entry_end = int'(sel >> 3) * 8 + 7;
            if (entry_end > lim) begin
                code = 3'd3;
            end else begin
                nmem = 2;
                a0   = base + 32'(int'(sel >> 3) * 8);
                a1   = a0 + 32'd4;
                desc = {hi, lo};
                if (hi[12] == 1'b0) code = 3'd4;
                else if (hi[15] == 1'b0) code = (idx == 3'd2) ? 3'd6 : 3'd5;
                else we = 1'b1;
            end
        end
    endfunction

    task automatic clear_log();
        addr_q.delete();
        obs_done_cnt = 0; obs_we_cnt = 0; stab_err = 0; obs_timeout = 1'b0;
        obs_fault = 1'b0; obs_code = '0; obs_wi = '0; obs_ws = '0; obs_wd = '0;
    endtask

    task automatic do_load(input logic [2:0] idx, input logic [15:0] sel);
        clear_log();
        @(posedge clock); #1;
        load_index = idx; load_selector = sel; load_valid = 1'b1;
        @(negedge clock);
        acc_cyc = cyc;
        @(posedge clock); #1;
        load_valid = 1'b0; load_index = 3'($urandom); load_selector = 16'($urandom);
        for (int k = 0; k < 80 && obs_done_cnt == 0; k++) @(posedge clock);
        if (obs_done_cnt == 0) obs_timeout = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if ({write_enable, done_valid, fault, fault_code} !== 6'd0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {write_enable, done_valid, fault, fault_code}); end
        n_checks++; if (write_descriptor !== 64'd0 || mem_req_address !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0", write_descriptor, mem_req_address); end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_ds_load();
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF; rnd_ready = 1'b0;
        mem_arr[32'h1010] = 32'h0000FFFF;
        mem_arr[32'h1014] = 32'h00CF9200;
        do_load(3'd3, 16'h0010);
        n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL ds_timeout: got no done want done"); end
        n_checks++; if (addr_q.size() != 2) begin n_fail++; $display("FAIL ds_req_count: got %0d want 2", addr_q.size()); end
        if (addr_q.size() == 2) begin
            n_checks++; if (addr_q[0] !== 32'h1010 || addr_q[1] !== 32'h1014) begin n_fail++; $display("FAIL ds_addr: got %h %h want 1010 1014", addr_q[0], addr_q[1]); end
        end
        n_checks++; if (obs_done_cyc - acc_cyc != 7) begin n_fail++; $display("FAIL ds_latency: got %0d want 7", obs_done_cyc - acc_cyc); end
        n_checks++; if (obs_fault !== 1'b0 || obs_code !== 3'd0) begin n_fail++; $display("FAIL ds_fault: got %b/%0d want 0/0", obs_fault, obs_code); end
        n_checks++; if (obs_we_cnt != 1 || obs_wi !== 3'd3 || obs_ws !== 16'h0010) begin n_fail++; $display("FAIL ds_write: got cnt %0d idx %0d sel %h want 1 3 0010", obs_we_cnt, obs_wi, obs_ws); end
        n_checks++; if (obs_wd !== 64'h00CF92000000FFFF) begin n_fail++; $display("FAIL ds_desc: got %h want 00cf92000000ffff", obs_wd); end
    endtask

    task automatic test_null_selector();
        do_load(3'd2, 16'h0000);
        n_checks++; if (obs_code !== 3'd2 || obs_fault !== 1'b1) begin n_fail++; $display("FAIL null_ss_code: got %b/%0d want 1/2", obs_fault, obs_code); end
        n_checks++; if (addr_q.size() != 0 || obs_we_cnt != 0) begin n_fail++; $display("FAIL null_ss_side: got req %0d we %0d want 0 0", addr_q.size(), obs_we_cnt); end
        n_checks++; if (obs_done_cyc - acc_cyc != 2 || obs_done_cnt != 1) begin n_fail++; $display("FAIL null_ss_latency: got %0d cnt %0d want 2 1", obs_done_cyc - acc_cyc, obs_done_cnt); end
        do_load(3'd0, 16'h0000);
        n_checks++; if (obs_we_cnt != 1 || obs_wi !== 3'd0 || obs_wd !== 64'd0 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL null_es_write: got cnt %0d idx %0d desc %h fault %b want 1 0 0 0", obs_we_cnt, obs_wi, obs_wd, obs_fault); end
        n_checks++; if (addr_q.size() != 0 || obs_done_cyc - acc_cyc != 2) begin n_fail++; $display("FAIL null_es_timing: got req %0d lat %0d want 0 2", addr_q.size(), obs_done_cyc - acc_cyc); end
    endtask

    task automatic test_ldt_limit();
        ldtr_base = 32'h0002_0000; ldtr_limit = 16'h00FF;
        do_load(3'd3, 16'h0104);
        n_checks++; if (obs_code !== 3'd3 || addr_q.size() != 0 || obs_we_cnt != 0) begin n_fail++; $display("FAIL ldt_limit: got code %0d req %0d we %0d want 3 0 0", obs_code, addr_q.size(), obs_we_cnt); end
        n_checks++; if (obs_done_cyc - acc_cyc != 2) begin n_fail++; $display("FAIL ldt_limit_latency: got %0d want 2", obs_done_cyc - acc_cyc); end
        ldtr_limit = 16'h0107;
        mem_arr[32'h0002_0100] = 32'h1234_5678;
        mem_arr[32'h0002_0104] = 32'h00CF_9300;
        do_load(3'd3, 16'h0104);
        n_checks++; if (addr_q.size() != 2 || obs_code !== 3'd0) begin n_fail++; $display("FAIL ldt_edge: got req %0d code %0d want 2 0", addr_q.size(), obs_code); end
        if (addr_q.size() > 0) begin
            n_checks++; if (addr_q[0] !== 32'h0002_0100) begin n_fail++; $display("FAIL ldt_addr: got %h want 00020100", addr_q[0]); end
        end
    endtask

    task automatic test_validate_faults();
        logic [2:0]  idx_t  [3] = '{3'd2, 3'd5, 3'd3};
        logic [31:0] hi_t   [3] = '{32'h00CF1200, 32'h00CF1200, 32'h00CF8200};
        logic [2:0]  code_t [3] = '{3'd6, 3'd5, 3'd4};
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            mem_arr[32'h1010] = 32'h0000FFFF;
            mem_arr[32'h1014] = hi_t[i];
            do_load(idx_t[i], 16'h0010);
            n_checks++; if (obs_code !== code_t[i] || obs_fault !== 1'b1) begin n_fail++; $display("FAIL validate_%0d: got %b/%0d want 1/%0d", i, obs_fault, obs_code, code_t[i]); end
            n_checks++; if (obs_we_cnt != 0 || addr_q.size() != 2 || obs_done_cyc - acc_cyc != 7) begin n_fail++; $display("FAIL validate_side_%0d: got we %0d req %0d lat %0d want 0 2 7", i, obs_we_cnt, addr_q.size(), obs_done_cyc - acc_cyc); end
        end
    endtask

    task automatic test_stall();
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF;
        mem_arr[32'h1010] = 32'h0000FFFF;
        mem_arr[32'h1014] = 32'h00CF9200;
        stall_left = 3;
        do_load(3'd3, 16'h0010);
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        n_checks++; if (addr_q.size() != 2 || obs_done_cyc - acc_cyc != 10) begin n_fail++; $display("FAIL stall_timing: got req %0d lat %0d want 2 10", addr_q.size(), obs_done_cyc - acc_cyc); end
        if (addr_q.size() > 0) begin
            n_checks++; if (addr_q[0] !== 32'h1010) begin n_fail++; $display("FAIL stall_addr: got %h want 1010", addr_q[0]); end
        end
        n_checks++; if (obs_wd !== 64'h00CF92000000FFFF || obs_we_cnt != 1) begin n_fail++; $display("FAIL stall_desc: got %h cnt %0d want 00cf92000000ffff 1", obs_wd, obs_we_cnt); end
        do_load(3'd7, 16'h0010);
        n_checks++; if (obs_code !== 3'd1 || addr_q.size() != 0 || obs_we_cnt != 0 || obs_done_cyc - acc_cyc != 2) begin n_fail++; $display("FAIL bad_index: got code %0d req %0d we %0d lat %0d want 1 0 0 2", obs_code, addr_q.size(), obs_we_cnt, obs_done_cyc - acc_cyc); end
    endtask

    task automatic test_mid_reset();
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF; rnd_ready = 1'b0;
        mem_arr[32'h1010] = 32'h0000FFFF;
        mem_arr[32'h1014] = 32'h00CF9200;
        clear_log();
        @(posedge clock); #1;
        load_index = 3'd3; load_selector = 16'h0010; load_valid = 1'b1;
        @(posedge clock); #1;
        load_valid = 1'b0;
        for (int k = 0; k < 40 && addr_q.size() < 2; k++) @(posedge clock);
        #1;
        n_checks++; if (addr_q.size() != 2) begin n_fail++; $display("FAIL midrst_reach: got %0d reqs want 2", addr_q.size()); end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        n_checks++; if (obs_done_cnt != 0 || obs_we_cnt != 0) begin n_fail++; $display("FAIL midrst_abort: got done %0d we %0d want 0 0", obs_done_cnt, obs_we_cnt); end
        @(negedge clock);
        n_checks++; if (load_ready !== 1'b1 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got ready %b req %b want 1 0", load_ready, mem_req_valid); end
        clear_log();
        stray = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        n_checks++; if (obs_done_cnt != 0 || obs_we_cnt != 0 || addr_q.size() != 0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL stray_rsp: got done %0d we %0d req %0d ready %b want 0 0 0 1", obs_done_cnt, obs_we_cnt, addr_q.size(), load_ready); end
        @(posedge clock);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [2:0]  idx;
            logic [15:0] sel;
            logic [31:0] lo;
            logic [31:0] hi;
            logic [2:0]  ecode;
            int          enm;
            logic [31:0] ea0;
            logic [31:0] ea1;
            logic        ewe;
            logic [63:0] edesc;
            idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) idx = 3'd3;
            case ($urandom_range(0, 4))
                0:       sel = 16'($urandom_range(0, 3));
                1:       sel = 16'($urandom);
                default: sel = 16'(($urandom_range(1, 48) << 3) | $urandom_range(0, 7));
            endcase
            gdtr_limit = 16'($urandom_range(0, 400));
            ldtr_limit = 16'($urandom_range(0, 400));
            gdtr_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : $urandom;
            ldtr_base  = $urandom;
            lo = $urandom;
            hi = $urandom;
            hi[12] = ($urandom_range(0, 9) < 7);
            hi[15] = ($urandom_range(0, 9) < 7);
            rnd_ready = 1'($urandom_range(0, 1));
            model(idx, sel, lo, hi, ecode, enm, ea0, ea1, ewe, edesc);
            if (enm == 2) begin
                mem_arr[ea0] = lo;
                mem_arr[ea1] = hi;
            end
            do_load(idx, sel);
            n_checks++; if (obs_timeout || obs_done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done: got cnt %0d timeout %b want 1 0", it, obs_done_cnt, obs_timeout); end
            n_checks++; if (obs_code !== ecode || obs_fault !== (ecode != 3'd0)) begin n_fail++; $display("FAIL rnd%0d_code: got %b/%0d want %b/%0d (idx %0d sel %h)", it, obs_fault, obs_code, ecode != 3'd0, ecode, idx, sel); end
            n_checks++; if (obs_we_cnt != (ewe ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_we: got %0d want %0d", it, obs_we_cnt, ewe ? 1 : 0); end
            if (ewe) begin
                n_checks++; if (obs_wi !== idx || obs_ws !== sel || obs_wd !== edesc) begin n_fail++; $display("FAIL rnd%0d_wdata: got %0d %h %h want %0d %h %h", it, obs_wi, obs_ws, obs_wd, idx, sel, edesc); end
            end
            n_checks++; if (addr_q.size() != enm) begin n_fail++; $display("FAIL rnd%0d_reqs: got %0d want %0d", it, addr_q.size(), enm); end
            if (enm == 2 && addr_q.size() == 2) begin
                n_checks++; if (addr_q[0] !== ea0 || addr_q[1] !== ea1) begin n_fail++; $display("FAIL rnd%0d_addr: got %h %h want %h %h", it, addr_q[0], addr_q[1], ea0, ea1); end
            end
            n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0", it, stab_err); end
            if (!rnd_ready) begin
                n_checks++; if (obs_done_cyc - acc_cyc != ((enm == 2) ? 7 : 2)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, obs_done_cyc - acc_cyc, (enm == 2) ? 7 : 2); end
            end
        end
        rnd_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ds_load();
        test_null_selector();
        test_ldt_limit();
        test_validate_faults();
        test_stall();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
